// File: rtl/conv_encoder.sv
// Rate-1/2 feedforward convolutional encoder with valid/ready streaming and K-1 zero tail bits per frame.
// Optional rate-2/3 puncturing ([11;10] pattern) is compiled in with the CONV_PUNCT_EN macro.
module conv_encoder #(
    parameter int             K  = 7,
    parameter logic [K-1:0]   G0 = 7'o171,
    parameter logic [K-1:0]   G1 = 7'o133
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_enc,
    input  logic       i_bit,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [1:0] o_code,
    output logic       o_valid,
    output logic       o_last,
    input  logic       i_ready,
`ifdef CONV_PUNCT_EN
    input  logic       i_punct,
    output logic [1:0] o_mask,
`endif
    output logic [1:0] dbg_state
);

    localparam int SW = K - 1;
    localparam int TW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] sr;
    logic [TW-1:0] tail_cnt, tail_cnt_nx;
    logic          accept, tail_step, step, last_step, in_bit;
    logic [K-1:0]  tap_v;
    logic [1:0]    code;

    // Valid/ready: a beat transfers on a rising edge where valid & ready are both high;
    // a producer holding valid keeps its payload stable until that edge.
    assign o_ready   = rst & en_enc & (state != TAIL) & (!o_valid | i_ready);
    assign accept    = i_valid & o_ready;
    assign tail_step = en_enc & (state == TAIL) & (!o_valid | i_ready);
    assign step      = accept | tail_step;
    assign last_step = tail_step & (tail_cnt == TW'(1));
    assign in_bit    = accept & i_bit;

    // sr[SW-1] is the most recent bit, so the input lands on the generator MSB.
    assign tap_v     = {in_bit, sr};
    assign code      = {^(tap_v & G0), ^(tap_v & G1)};
    assign dbg_state = state;

    always_comb begin
        state_nx    = state;
        tail_cnt_nx = tail_cnt;
        case (state)
            IDLE, ENC: begin
                if (accept) begin
                    if (i_last) begin
                        state_nx    = TAIL;
                        tail_cnt_nx = TW'(K - 1);
                    end else begin
                        state_nx = ENC;
                    end
                end
            end
            TAIL: begin
                if (tail_step) begin
                    tail_cnt_nx = tail_cnt - TW'(1);
                    if (tail_cnt == TW'(1)) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tail_cnt <= '0;
            sr       <= '0;
            o_code   <= 2'b00;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            state    <= state_nx;
            tail_cnt <= tail_cnt_nx;
            if (step) begin
                sr      <= {in_bit, sr[SW-1:1]};
                o_code  <= code;
                o_valid <= 1'b1;
                o_last  <= last_step;
            end else if (i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

`ifdef CONV_PUNCT_EN
    // Mask is registered with its codeword; phase counts codewords produced in the frame,
    // which matches the transfer order since every codeword transfers exactly once.
    logic punct_r, phase, punct_eff;

    assign punct_eff = (state == IDLE) ? i_punct : punct_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            punct_r <= 1'b0;
            phase   <= 1'b0;
            o_mask  <= 2'b11;
        end else begin
            if (accept && (state == IDLE)) punct_r <= i_punct;
            if (step) begin
                o_mask <= (punct_eff & phase) ? 2'b10 : 2'b11;
                phase  <= last_step ? 1'b0 : ~phase;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: a K=3 instance for most scenarios and a default K=7 instance,
// both checked through expected-value queues filled by a bench-side encoder model.
module tb_conv_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs        = 0;
    int miscompares = 0;

    localparam logic [8:0] G0_3 = 9'b000000111;
    localparam logic [8:0] G1_3 = 9'b000000101;
    localparam logic [8:0] G0_7 = 9'o171;
    localparam logic [8:0] G1_7 = 9'o133;

    // ---------------- clock/reset, DUT signals ----------------
    logic       en3 = 1'b1, i_bit3 = 1'b0, i_valid3 = 1'b0, i_last3 = 1'b0, i_ready3 = 1'b1;
    logic       o_ready3, o_valid3, o_last3;
    logic [1:0] o_code3, dbg3;
    logic       i_punct3 = 1'b0;
    logic       en7 = 1'b1, i_bit7 = 1'b0, i_valid7 = 1'b0, i_last7 = 1'b0, i_ready7 = 1'b1;
    logic       o_ready7, o_valid7, o_last7;
    logic [1:0] o_code7, dbg7;
`ifdef CONV_PUNCT_EN
    logic [1:0] o_mask3, o_mask7;
    logic       i_punct7 = 1'b0;
`endif

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101)) dut3 (
        .clk(clk), .rst(rst), .en_enc(en3), .i_bit(i_bit3), .i_valid(i_valid3),
        .i_last(i_last3), .o_ready(o_ready3), .o_code(o_code3), .o_valid(o_valid3),
        .o_last(o_last3), .i_ready(i_ready3),
`ifdef CONV_PUNCT_EN
        .i_punct(i_punct3), .o_mask(o_mask3),
`endif
        .dbg_state(dbg3)
    );

    conv_encoder dut7 (
        .clk(clk), .rst(rst), .en_enc(en7), .i_bit(i_bit7), .i_valid(i_valid7),
        .i_last(i_last7), .o_ready(o_ready7), .o_code(o_code7), .o_valid(o_valid7),
        .o_last(o_last7), .i_ready(i_ready7),
`ifdef CONV_PUNCT_EN
        .i_punct(i_punct7), .o_mask(o_mask7),
`endif
        .dbg_state(dbg7)
    );

    // Downstream ready for dut3: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    int rdy_mode = 0;
    int rdy_idx  = 0;
    always @(posedge clk) begin
        #1;
        rdy_idx = rdy_idx + 1;
        case (rdy_mode)
            0:       i_ready3 = 1'b1;
            1:       i_ready3 = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
            default: i_ready3 = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- model and scoreboard ----------------
    logic [2:0] exp3_q[$];
    logic [2:0] exp7_q[$];
    logic [1:0] mexp3_q[$];
    logic [7:0] m_sr3 = '0, m_sr7 = '0;
    logic       m_first3 = 1'b1, m_phase3 = 1'b0, m_punct3 = 1'b0;
    logic       table_mode = 1'b0;
    int         acc_cyc3 = 0, last_xfer3 = 0, waits3 = 0;

    function automatic logic [1:0] model_code(input int k, input logic [7:0] sr, input logic in,
                                              input logic [8:0] g0, input logic [8:0] g1);
        logic p0, p1;
        p0 = in & g0[k-1];
        p1 = in & g1[k-1];
        for (int i = 0; i < k - 1; i++) begin
            p0 = p0 ^ (sr[i] & g0[i]);
            p1 = p1 ^ (sr[i] & g1[i]);
        end
        return {p0, p1};
    endfunction

    function automatic logic [7:0] model_shift(input int k, input logic [7:0] sr, input logic in);
        logic [7:0] s;
        s = sr >> 1;
        s[k-2] = in;
        return s;
    endfunction

    task automatic push_mask3();
        mexp3_q.push_back((m_punct3 && m_phase3) ? 2'b10 : 2'b11);
        m_phase3 = ~m_phase3;
    endtask

    task automatic push3(input logic in, input logic last);
        logic [1:0] c;
        if (m_first3) begin
            m_punct3 = i_punct3;
            m_phase3 = 1'b0;
        end
        m_first3 = last;
        c = model_code(3, m_sr3, in, G0_3, G1_3);
        if (!table_mode) exp3_q.push_back({1'b0, c});
        push_mask3();
        m_sr3 = model_shift(3, m_sr3, in);
        if (last) begin
            for (int t = 0; t < 2; t++) begin
                c = model_code(3, m_sr3, 1'b0, G0_3, G1_3);
                if (!table_mode) exp3_q.push_back({(t == 1), c});
                push_mask3();
                m_sr3 = model_shift(3, m_sr3, 1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            vecs++;
            if (o_last3 && !o_valid3) begin
                miscompares++;
                $display("FAIL last3_without_valid: o_last=1 o_valid=0, required o_valid=1");
            end
            if (o_valid3) begin
                vecs++;
                if (exp3_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL code3_extra: got last=%0b code=%b, required no codeword", o_last3, o_code3);
                end else begin
                    if ({o_last3, o_code3} !== exp3_q[0]) begin
                        miscompares++;
                        $display("FAIL code3: got {last,code}=%b, required %b", {o_last3, o_code3}, exp3_q[0]);
                    end
`ifdef CONV_PUNCT_EN
                    vecs++;
                    if (o_mask3 !== mexp3_q[0]) begin
                        miscompares++;
                        $display("FAIL mask3: got %b, required %b", o_mask3, mexp3_q[0]);
                    end
`endif
                    if (i_ready3) begin
                        exp3_q.delete(0);
                        if (mexp3_q.size() != 0) mexp3_q.delete(0);
                        if (o_last3) last_xfer3 = cyc;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && o_valid7) begin
            vecs++;
            if (exp7_q.size() == 0) begin
                miscompares++;
                $display("FAIL code7_extra: got last=%0b code=%b, required no codeword", o_last7, o_code7);
            end else begin
                if ({o_last7, o_code7} !== exp7_q[0]) begin
                    miscompares++;
                    $display("FAIL code7: got {last,code}=%b, required %b", {o_last7, o_code7}, exp7_q[0]);
                end
                if (i_ready7) exp7_q.delete(0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit3(input logic in, input logic last);
        int  n;
        logic accepted;
        n = 0;
        accepted = 1'b0;
        waits3 = 0;
        i_bit3 = in;
        i_last3 = last;
        i_valid3 = 1'b1;
        while (!accepted && n < 200) begin
            @(negedge clk);
            if (o_ready3) begin
                accepted = 1'b1;
                acc_cyc3 = cyc;
                push3(in, last);
            end else begin
                waits3++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        i_valid3 = 1'b0;
        i_last3 = 1'b0;
        if (!accepted) begin
            vecs++;
            miscompares++;
            $display("FAIL accept3_timeout: o_ready stayed 0 for %0d cycles, required accept", n);
        end
    endtask

    task automatic send_frame3(input logic [15:0] bits, input int len);
        for (int i = 0; i < len; i++) send_bit3(bits[i], (i == len - 1));
    endtask

    task automatic wait_drain3();
        int n;
        n = 0;
        while (exp3_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        vecs++;
        if (exp3_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain3: %0d codewords missing, required 0", exp3_q.size());
            exp3_q.delete();
            mexp3_q.delete();
        end
    endtask

    task automatic run_ref_frame3();
        logic [2:0] tbl[6];
        tbl = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        for (int i = 0; i < 6; i++) exp3_q.push_back(tbl[i]);
        table_mode = 1'b1;
        send_frame3(16'b1101, 4);
        table_mode = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        vecs++;
        if ({o_valid3, o_last3, o_code3} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset3_out: got valid,last,code=%b, required 0000", {o_valid3, o_last3, o_code3});
        end
        vecs++;
        if (o_ready3 !== 1'b0 || o_ready7 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b%b, required 00", o_ready3, o_ready7);
        end
        vecs++;
        if (dbg3 !== 2'd0 || dut3.sr !== 2'b00) begin
            miscompares++;
            $display("FAIL reset3_state: got state=%0d sr=%b, required 0/00", dbg3, dut3.sr);
        end
        vecs++;
        if ({o_valid7, o_last7, o_code7} !== 4'b0000 || dut7.sr !== 6'd0) begin
            miscompares++;
            $display("FAIL reset7: got out=%b sr=%b, required 0", {o_valid7, o_last7, o_code7}, dut7.sr);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int nz;
        run_ref_frame3();
        nz = 0;
        repeat (4) begin
            @(negedge clk);
            if (!o_ready3) nz++;
        end
        vecs++;
        if (nz !== 2) begin
            miscompares++;
            $display("FAIL tail_ready_low: got %0d cycles of o_ready=0, required 2", nz);
        end
        wait_drain3();
    endtask

    task automatic test_stall();
        rdy_mode = 1;
        run_ref_frame3();
        wait_drain3();
        rdy_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single7();
        int n;
        exp7_q.push_back(3'b011);
        m_sr7 = model_shift(7, m_sr7, 1'b1);
        for (int t = 0; t < 6; t++) begin
            exp7_q.push_back({(t == 5), model_code(7, m_sr7, 1'b0, G0_7, G1_7)});
            m_sr7 = model_shift(7, m_sr7, 1'b0);
        end
        i_bit7 = 1'b1;
        i_last7 = 1'b1;
        i_valid7 = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (o_ready7) break;
        end
        @(posedge clk);
        #1;
        i_valid7 = 1'b0;
        i_last7 = 1'b0;
        n = 0;
        while (exp7_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        vecs++;
        if (exp7_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain7: %0d codewords missing, required 0", exp7_q.size());
            exp7_q.delete();
        end
        vecs++;
        if (dut7.sr !== 6'd0 || dbg7 !== 2'd0) begin
            miscompares++;
            $display("FAIL single7_end: got sr=%b state=%0d, required 000000/0", dut7.sr, dbg7);
        end
    endtask

    task automatic test_enable();
        logic [15:0] bits;
        bits = 16'($urandom());
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                en3 = 1'b0;
                i_valid3 = 1'b1;
                i_bit3 = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    vecs++;
                    if (o_ready3 !== 1'b0 || dbg3 !== 2'd1 || dut3.sr !== m_sr3[1:0]) begin
                        miscompares++;
                        $display("FAIL enable_hold: got ready=%b state=%0d sr=%b, required 0/1/%b",
                                 o_ready3, dbg3, dut3.sr, m_sr3[1:0]);
                    end
                    @(posedge clk);
                    #1;
                end
                en3 = 1'b1;
            end
            send_bit3(bits[i], (i == 7));
        end
        wait_drain3();
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        bits = 16'($urandom());
        send_frame3(bits, 5);
        send_bit3(1'($urandom_range(0, 1)), 1'b1);
        vecs++;
        if (waits3 !== 2) begin
            miscompares++;
            $display("FAIL tail_block: got %0d refused cycles, required 2", waits3);
        end
        vecs++;
        if (acc_cyc3 < last_xfer3 || acc_cyc3 > last_xfer3 + 1) begin
            miscompares++;
            $display("FAIL b2b_gap: got accept at %0d, o_last xfer at %0d, required gap 0..1",
                     acc_cyc3, last_xfer3);
        end
        wait_drain3();
    endtask

    task automatic test_random_ready();
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) send_frame3(16'($urandom()), $urandom_range(1, 10));
        wait_drain3();
        rdy_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_tail();
        send_frame3(16'b1101, 4);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        vecs++;
        if ({o_valid3, o_last3, o_code3} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_out: got valid,last,code=%b, required 0000", {o_valid3, o_last3, o_code3});
        end
        vecs++;
        if (o_ready3 !== 1'b0 || dbg3 !== 2'd0 || dut3.sr !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_state: got ready=%b state=%0d sr=%b, required 0/0/00",
                     o_ready3, dbg3, dut3.sr);
        end
        exp3_q.delete();
        mexp3_q.delete();
        m_sr3 = '0;
        m_first3 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_ref_frame3();
        wait_drain3();
    endtask

`ifdef CONV_PUNCT_EN
    task automatic test_punct();
        i_punct3 = 1'b1;
        run_ref_frame3();
        i_punct3 = 1'b0;
        wait_drain3();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_single7();
        test_enable();
        test_back_to_back();
        test_random_ready();
        test_reset_tail();
`ifdef CONV_PUNCT_EN
        test_punct();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
